uart_msg_sequencer: RTL and testbench

- Upstream feeder for the UART byte transmitter.
- Debounces four active-low push buttons and converts each press into a fixed ASCII message from an internal ROM.
- Streams the message one byte at a time over a valid/ready handshake into the transmitter's byte input.
- Replaces ad-hoc string shifting and zero-byte padding: sends exact message lengths, one message at a time.

---
 rtl/uart_msg_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_uart_msg_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_sequencer.sv
// Debounces four active-low buttons and streams a fixed ASCII message per press
// over a valid/ready byte handshake. Optional hold-to-repeat: UART_MSG_AUTO_REPEAT_EN.
module uart_msg_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic [1:0] msg_id
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t      r_state;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_deb;
    logic [3:0]  r_deb_d;
    logic [DB_W-1:0] r_db_cnt [4];
    logic [2:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic [1:0]  r_msg_id;

    logic [3:0]  w_press;
    logic [3:0]  w_rep_press;
    logic [3:0]  w_start_vec;
    logic        w_start;
    logic [1:0]  w_sel;

    function automatic logic [7:0] rom_byte(input logic [1:0] id, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case ({id, idx})
            {2'd0, 3'd0}: b = "s";
            {2'd0, 3'd1}: b = "e";
            {2'd0, 3'd2}: b = "a";
            {2'd0, 3'd3}: b = "n";
            {2'd0, 3'd4}: b = 8'h0D;
            {2'd0, 3'd5}: b = 8'h0A;
            {2'd1, 3'd0}: b = "w";
            {2'd1, 3'd1}: b = "a";
            {2'd1, 3'd2}: b = "s";
            {2'd1, 3'd3}: b = " ";
            {2'd1, 3'd4}: b = 8'h0D;
            {2'd1, 3'd5}: b = 8'h0A;
            {2'd2, 3'd0}: b = "e";
            {2'd2, 3'd1}: b = "r";
            {2'd2, 3'd2}: b = "e";
            {2'd2, 3'd3}: b = " ";
            {2'd2, 3'd4}: b = 8'h0D;
            {2'd2, 3'd5}: b = 8'h0A;
            {2'd3, 3'd0}: b = "#";
            {2'd3, 3'd1}: b = "1";
            {2'd3, 3'd2}: b = "2";
            {2'd3, 3'd3}: b = "3";
            {2'd3, 3'd4}: b = "4";
            {2'd3, 3'd5}: b = "5";
            {2'd3, 3'd6}: b = 8'h0A;
            default:      b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] id);
        return (id == 2'd3) ? 3'd6 : 3'd5;
    endfunction

    // Two-flop synchronizer, then a per-button stability counter.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_deb   <= 4'b1111;
            r_deb_d <= 4'b1111;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb_d & ~r_deb;

`ifdef UART_MSG_AUTO_REPEAT_EN
    localparam int RP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RP_W-1:0] r_rep_cnt;
    logic            w_rep_hold;
    logic            w_rep_fire;

    assign w_rep_hold = (r_state == ST_IDLE) && !r_deb[r_msg_id];
    assign w_rep_fire = w_rep_hold && (r_rep_cnt == RP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_rep_hold || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rep_press = 4'b0000;
        if (w_rep_fire) w_rep_press[r_msg_id] = 1'b1;
    end
`else
    // Repeat disabled: the parameter only keeps the interface identical across builds.
    assign w_rep_press = (REPEAT_CYCLES < 0) ? 4'b1111 : 4'b0000;
`endif

    assign w_start_vec = w_press | w_rep_press;
    assign w_start     = |w_start_vec;

    always_comb begin
        // NOTE: default first so no path leaves w_sel unassigned and infers a latch.
        w_sel = 2'd0;
        if      (w_start_vec[0]) w_sel = 2'd0;
        else if (w_start_vec[1]) w_sel = 2'd1;
        else if (w_start_vec[2]) w_sel = 2'd2;
        else if (w_start_vec[3]) w_sel = 2'd3;
    end

    // Presses arriving while a message is in flight are dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_data   <= 8'h00;
            r_busy   <= 1'b0;
            r_msg_id <= 2'd0;
            r_idx    <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_msg_id <= w_sel;
                        r_idx    <= 3'd0;
                        r_data   <= rom_byte(w_sel, 3'd0);
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_ready) begin
                        if (r_idx == last_idx(r_msg_id)) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_data <= rom_byte(r_msg_id, r_idx + 3'd1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_data  = r_data;
    assign byte_valid = r_valid;
    assign busy       = r_busy;
    assign msg_id     = r_msg_id;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer with shortened debounce/repeat intervals.
// Repeat expectations follow UART_MSG_AUTO_REPEAT_EN when it is defined.
module tb_uart_msg_sequencer;

    localparam int DB = 16;
    localparam int RP = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic [1:0] msg_id;

    always #5 clk = ~clk;

    uart_msg_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .busy      (busy),
        .msg_id    (msg_id)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_spur   = 0;
    int n_busy   = 0;
    int ready_div = 1;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_msg(input int id, input int nbytes);
        string s;
        case (id)
            0:       s = "sean\r\n";
            1:       s = "was \r\n";
            2:       s = "ere \r\n";
            default: s = "#12345\n";
        endcase
        for (int i = 0; i < nbytes && i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input string tag, input int budget);
        int t = 0;
        while (!busy && t < budget) begin
            tick(1);
            t++;
        end
        if (!busy) check({tag, "_start_timeout"}, busy, 1);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int t = 0;
        while (busy && t < budget) begin
            tick(1);
            t++;
        end
        if (busy) check({tag, "_end_timeout"}, busy, 0);
    endtask

    // Ready pattern: high on one cycle out of every ready_div.
    initial begin
        int ph = 0;
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            byte_ready = (ph % ready_div) == 0;
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, busy cycle count.
    initial begin
        logic [7:0] prev_data = 8'h00;
        logic [1:0] prev_id   = 2'd0;
        logic       prev_stall = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", byte_valid, 1);
                check("stall_data", byte_data, prev_data);
                check("stall_id", msg_id, prev_id);
            end
            if (busy) n_busy++;
            if (byte_valid && byte_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_spur++;
                end else begin
                    e = exp_q.pop_front();
                    check("byte", byte_data, e);
                end
            end
            prev_stall = byte_valid && !byte_ready && !rst;
            prev_data  = byte_data;
            prev_id    = msg_id;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int b0;
        rst   = 1'b1;
        btn_n = 4'b1111;
        tick(3);
        check("rst_valid", byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", byte_data, 8'h00);
        check("rst_id", msg_id, 0);
        rst = 1'b0;
        tick(5);

        // Message 0, ready always high: six back-to-back handshakes.
        ready_div = 1;
        a0 = n_acc;
        b0 = n_busy;
        btn_n = 4'b1110;
        push_msg(0, 6);
        wait_start("m0", DB + 50);
        wait_end("m0", 100);
        check("m0_count", n_acc - a0, 6);
        check("m0_busy_cycles", n_busy - b0, 6);
        check("m0_id", msg_id, 0);
`ifdef UART_MSG_AUTO_REPEAT_EN
        push_msg(0, 6);
        wait_start("m0_rep", RP + 100);
        wait_end("m0_rep", 100);
        check("m0_repeat_count", n_acc - a0, 12);
`else
        tick(RP + 500);
        check("m0_once", n_acc - a0, 6);
`endif
        btn_n = 4'b1111;
        tick(DB + 10);

        // Message 3 with a slow transmitter.
        ready_div = 3;
        a0 = n_acc;
        btn_n = 4'b0111;
        push_msg(3, 7);
        wait_start("m3", DB + 50);
        wait_end("m3", 200);
        check("m3_count", n_acc - a0, 7);
        check("m3_id", msg_id, 3);
        btn_n = 4'b1111;
        tick(DB + 10);

        // Short glitch on button 2 must not register; a solid hold must.
        ready_div = 1;
        a0 = n_acc;
        btn_n = 4'b1011;
        tick(DB / 2);
        btn_n = 4'b1111;
        tick(100);
        check("glitch_bytes", n_acc - a0, 0);
        check("glitch_busy", busy, 0);
        btn_n = 4'b1011;
        push_msg(2, 6);
        wait_start("m2", DB + 50);
        wait_end("m2", 100);
        check("m2_count", n_acc - a0, 6);
        check("m2_id", msg_id, 2);
        btn_n = 4'b1111;
        tick(DB + 10);

        // Buttons 1 and 3 together pick message 1; a press of 0 mid-message is dropped.
        ready_div = 8;
        a0 = n_acc;
        btn_n = 4'b0101;
        push_msg(1, 6);
        wait_start("m1", DB + 50);
        btn_n = 4'b0100;
        wait_end("m1", 200);
        check("m1_id", msg_id, 1);
        tick(200);
        check("m1_count", n_acc - a0, 6);
        check("m1_no_queue", busy, 0);
        btn_n = 4'b1111;
        tick(DB + 10);

        // Reset lands on the third handshake of message 0.
        ready_div = 1;
        a0 = n_acc;
        btn_n = 4'b1110;
        push_msg(0, 3);
        wait_start("mr", DB + 50);
        tick(2);
        rst   = 1'b1;
        btn_n = 4'b1111;
        tick(1);
        rst = 1'b0;
        check("mr_valid", byte_valid, 0);
        check("mr_busy", busy, 0);
        tick(200);
        check("mr_count", n_acc - a0, 3);

        check("spurious_bytes", n_spur, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
